inst_fetch_queue: RTL

- Buffers instruction words returned by the instruction-fetch Wishbone port, each tagged with its fetch PC, ahead of the decode stage.
- Decouples fetch from decode stalls.
- Drives the fetch-stall request so that the fetch FSM stops issuing cycles before the queue overflows.
- Discards all queued words on a control-flow redirect (flush).

---
 rtl/inst_fetch_queue_if.sv | 27 ++
 rtl/inst_fetch_queue.sv | 99 +++++++++
 2 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus: Wishbone fetch return path in, decode head entry out.
// master = fetch/decode side, slave = the queue.
interface inst_fetch_queue_if #(
   parameter int DEPTH_LOG2 = 2
);
   logic                  inst_ack_in;
   logic [31:0]           inst_in;
   logic [31:0]           inst_addr;
   logic                  flush;
   logic                  dec_ready;
   logic [31:0]           inst_out;
   logic [31:0]           pc_out;
   logic                  valid_out;
   logic                  stall_inst;
   logic [DEPTH_LOG2:0]   count;
   logic                  overflow;

   modport master (
      output inst_ack_in, inst_in, inst_addr, flush, dec_ready,
      input  inst_out, pc_out, valid_out, stall_inst, count, overflow
   );

   modport slave (
      input  inst_ack_in, inst_in, inst_addr, flush, dec_ready,
      output inst_out, pc_out, valid_out, stall_inst, count, overflow
   );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: buffers {pc, inst} words between the fetch port and decode.
// Optional macro IFQ_BYPASS_EN forwards a word straight to decode when the queue is empty.
module inst_fetch_queue #(
   parameter int DEPTH_LOG2   = 2,
   parameter int STALL_MARGIN = 1
) (
   input  logic               clk,
   input  logic               rst,
   inst_fetch_queue_if.slave  bus
);
   localparam int                  DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] DEPTH_C  = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] MARGIN_C = (DEPTH_LOG2+1)'(STALL_MARGIN);

   logic [63:0]           r_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] r_wr_ptr;
   logic [DEPTH_LOG2-1:0] r_rd_ptr;
   logic [DEPTH_LOG2:0]   r_count;
   logic                  r_stall;
   logic                  r_overflow;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_push_ok;
   logic                  w_push_q;
   logic                  w_bypass;
   logic                  w_bypass_take;
   logic [DEPTH_LOG2:0]   w_count_next;
   logic [DEPTH_LOG2:0]   w_free_next;
   logic [63:0]           w_head;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == DEPTH_C);
   assign w_push    = bus.inst_ack_in & ~bus.flush;
   assign w_pop     = ~w_empty & bus.dec_ready & ~bus.flush;
   assign w_push_ok = w_push & (~w_full | w_pop);

`ifdef IFQ_BYPASS_EN
   assign w_bypass      = w_push & w_empty;
   assign w_bypass_take = w_bypass & bus.dec_ready;
`else
   assign w_bypass      = 1'b0;
   assign w_bypass_take = 1'b0;
`endif

   // A bypassed word that decode takes immediately never occupies a slot.
   assign w_push_q     = w_push_ok & ~w_bypass_take;
   assign w_count_next = bus.flush ? '0
                       : r_count + (DEPTH_LOG2+1)'(w_push_q) - (DEPTH_LOG2+1)'(w_pop);
   assign w_free_next  = DEPTH_C - w_count_next;

   always_ff @(posedge clk) begin
      if (w_push_q) r_mem[r_wr_ptr] <= {bus.inst_addr, bus.inst_in};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_stall    <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push_q) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_count_next;
         r_stall <= bus.flush | (w_free_next <= MARGIN_C);
         if (w_push & w_full & ~w_pop) r_overflow <= 1'b1;
      end
   end

   assign w_head = r_mem[r_rd_ptr];

   always_comb begin
      bus.valid_out = 1'b0;
      bus.inst_out  = '0;
      bus.pc_out    = '0;
      if (!w_empty) begin
         bus.valid_out = 1'b1;
         bus.inst_out  = w_head[31:0];
         bus.pc_out    = w_head[63:32];
      end else if (w_bypass) begin
         bus.valid_out = 1'b1;
         bus.inst_out  = bus.inst_in;
         bus.pc_out    = bus.inst_addr;
      end
   end

   assign bus.stall_inst = r_stall;
   assign bus.count      = r_count;
   assign bus.overflow   = r_overflow;
endmodule
